vga_timing_gen: RTL and testbench

Generates the VGA raster: horizontal/vertical pixel counters, sync pulses, an active-video flag and a once-per-frame strobe, all aligned to a pixel-rate enable derived from the system clock. It is the upstream end of the pixel interface consumed by the scene renderer (`vga_controller`), which takes `x`/`y` and draws one 640x480 frame per 800x525 raster. It also latches the two player vertical positions once per frame, so the renderer never sees a position change mid-frame.

---
 rtl/vga_timing_gen.sv | 132 +++++++++++++
 tb/tb_vga_timing_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate enable, x/y counters, registered sync/active flags,
// frame strobe and once-per-frame latching of the player positions.
module vga_timing_gen #(
    parameter int CLK_DIV     = 2,
    parameter int H_SYNC      = 96,
    parameter int H_ACT_START = 144,
    parameter int H_ACT_END   = 784,
    parameter int H_TOTAL     = 800,
    parameter int V_SYNC      = 2,
    parameter int V_ACT_START = 35,
    parameter int V_ACT_END   = 515,
    parameter int V_TOTAL     = 525,
    parameter int RESET_POS   = 275
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] team1_pos_in,
    input  logic [9:0] team2_pos_in,
    output logic       pix_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hor_sync,
    output logic       ver_sync,
    output logic       active,
    output logic       frame_start,
    output logic [9:0] team1_ver_pos,
    output logic [9:0] team2_ver_pos,
    output logic [7:0] frame_cnt
);

    localparam logic       DIV_LAST     = 1'(CLK_DIV - 1);
    localparam logic       PIX_TICK_RST = (CLK_DIV == 1);
    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W     = 10'(H_SYNC);
    localparam logic [9:0] H_ACT_S_W    = 10'(H_ACT_START);
    localparam logic [9:0] H_ACT_E_W    = 10'(H_ACT_END);
    localparam logic [9:0] V_SYNC_W     = 10'(V_SYNC);
    localparam logic [9:0] V_ACT_S_W    = 10'(V_ACT_START);
    localparam logic [9:0] V_ACT_E_W    = 10'(V_ACT_END);
    localparam logic [9:0] RESET_POS_W  = 10'(RESET_POS);

    logic       div_cnt_q, div_cnt_d;
    logic       pix_tick_q, pix_tick_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       hor_sync_q, hor_sync_d;
    logic       ver_sync_q, ver_sync_d;
    logic       active_q, active_d;
    logic       frame_start_q, frame_start_d;
    logic [9:0] team1_q, team1_d;
    logic [9:0] team2_q, team2_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;

    logic div_wrap;
    logic line_end;
    logic frame_end;
    logic frame_wrap;

    // Counters advance on the cycle after the registered tick; flags look at the next x/y
    // so they line up with the counter values presented in the same cycle.
    always_comb begin
        div_wrap   = (div_cnt_q == DIV_LAST);
        div_cnt_d  = div_wrap ? 1'b0 : div_cnt_q + 1'b1;
        pix_tick_d = div_wrap;

        line_end   = (x_q == H_LAST);
        frame_end  = line_end && (y_q == V_LAST);
        frame_wrap = pix_tick_q && frame_end;

        x_d = x_q;
        y_d = y_q;
        if (pix_tick_q) begin
            if (line_end) begin
                x_d = 10'd0;
                y_d = frame_end ? 10'd0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end

        hor_sync_d = (x_d >= H_SYNC_W);
        ver_sync_d = (y_d >= V_SYNC_W);
        active_d   = (x_d >= H_ACT_S_W) && (x_d < H_ACT_E_W) &&
                     (y_d >= V_ACT_S_W) && (y_d < V_ACT_E_W);

        frame_start_d = frame_wrap;
        team1_d       = frame_wrap ? team1_pos_in : team1_q;
        team2_d       = frame_wrap ? team2_pos_in : team2_q;
        frame_cnt_d   = frame_wrap ? frame_cnt_q + 8'd1 : frame_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q     <= 1'b0;
            pix_tick_q    <= PIX_TICK_RST;
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            hor_sync_q    <= 1'b0;
            ver_sync_q    <= 1'b0;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
            team1_q       <= RESET_POS_W;
            team2_q       <= RESET_POS_W;
            frame_cnt_q   <= 8'd0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            pix_tick_q    <= pix_tick_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hor_sync_q    <= hor_sync_d;
            ver_sync_q    <= ver_sync_d;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
            team1_q       <= team1_d;
            team2_q       <= team2_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign pix_tick      = pix_tick_q;
    assign x             = x_q;
    assign y             = y_q;
    assign hor_sync      = hor_sync_q;
    assign ver_sync      = ver_sync_q;
    assign active        = active_q;
    assign frame_start   = frame_start_q;
    assign team1_ver_pos = team1_q;
    assign team2_ver_pos = team2_q;
    assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: one full-size raster instance for line timing and two
// reduced-geometry instances (16x10 raster) for window, frame-wrap, reset and wrap-count cases.
module tb_vga_timing_gen;

    typedef struct {
        int         pixel;
        logic [9:0] ex;
        logic [9:0] ey;
        logic       ehs;
        logic       evs;
        logic       eact;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstFull = 1'b0;
    logic rstSmall = 1'b0;
    logic rstFast = 1'b0;
    logic [9:0] t1In = 10'd0;
    logic [9:0] t2In = 10'd0;

    logic       fullTick, fullHs, fullVs, fullAct, fullFs;
    logic [9:0] fullX, fullY, fullP1, fullP2;
    logic [7:0] fullFc;
    logic       smTick, smHs, smVs, smAct, smFs;
    logic [9:0] smX, smY, smP1, smP2;
    logic [7:0] smFc;
    logic       faTick, faHs, faVs, faAct, faFs;
    logic [9:0] faX, faY, faP1, faP2;
    logic [7:0] faFc;

    vga_timing_gen dutFull (
        .clk(clk), .rst_n(rstFull), .team1_pos_in(t1In), .team2_pos_in(t2In),
        .pix_tick(fullTick), .x(fullX), .y(fullY), .hor_sync(fullHs), .ver_sync(fullVs),
        .active(fullAct), .frame_start(fullFs), .team1_ver_pos(fullP1),
        .team2_ver_pos(fullP2), .frame_cnt(fullFc)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_SYNC(4), .H_ACT_START(6), .H_ACT_END(14), .H_TOTAL(16),
        .V_SYNC(2), .V_ACT_START(3), .V_ACT_END(9), .V_TOTAL(10), .RESET_POS(275)
    ) dutSmall (
        .clk(clk), .rst_n(rstSmall), .team1_pos_in(t1In), .team2_pos_in(t2In),
        .pix_tick(smTick), .x(smX), .y(smY), .hor_sync(smHs), .ver_sync(smVs),
        .active(smAct), .frame_start(smFs), .team1_ver_pos(smP1),
        .team2_ver_pos(smP2), .frame_cnt(smFc)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_SYNC(4), .H_ACT_START(6), .H_ACT_END(14), .H_TOTAL(16),
        .V_SYNC(2), .V_ACT_START(3), .V_ACT_END(9), .V_TOTAL(10), .RESET_POS(275)
    ) dutFast (
        .clk(clk), .rst_n(rstFast), .team1_pos_in(t1In), .team2_pos_in(t2In),
        .pix_tick(faTick), .x(faX), .y(faY), .hor_sync(faHs), .ver_sync(faVs),
        .active(faAct), .frame_start(faFs), .team1_ver_pos(faP1),
        .team2_ver_pos(faP2), .frame_cnt(faFc)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fsFullCnt = 0;
    int fsSmallCnt = 0;

    // Count frame strobes mid-cycle so every one-clock pulse is seen exactly once.
    always @(negedge clk) begin
        if (fullFs) fsFullCnt <= fsFullCnt + 1;
        if (smFs) fsSmallCnt <= fsSmallCnt + 1;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    // With CLK_DIV=2 pixel p (p>=1) is first shown right after edge 2p+1 following release.
    task automatic gotoPixel(input int rel, input int p);
        tick(rel + 2 * p + 1 - cyc);
    endtask

    task automatic applyStimulus(input logic [9:0] t1, input logic [9:0] t2);
        t1In = t1;
        t2In = t2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic checkVec(input string tag, input vec_t v, input logic [9:0] ax,
                            input logic [9:0] ay, input logic ahs, input logic avs,
                            input logic aact);
        checkOutput($sformatf("%s_p%0d_x", tag, v.pixel), 32'(ax), 32'(v.ex));
        checkOutput($sformatf("%s_p%0d_y", tag, v.pixel), 32'(ay), 32'(v.ey));
        checkOutput($sformatf("%s_p%0d_hs", tag, v.pixel), 32'(ahs), 32'(v.ehs));
        checkOutput($sformatf("%s_p%0d_vs", tag, v.pixel), 32'(avs), 32'(v.evs));
        checkOutput($sformatf("%s_p%0d_act", tag, v.pixel), 32'(aact), 32'(v.eact));
    endtask

    task automatic checkSmallReset(input string tag);
        checkOutput({tag, "_tick"}, 32'(smTick), 0);
        checkOutput({tag, "_x"}, 32'(smX), 0);
        checkOutput({tag, "_y"}, 32'(smY), 0);
        checkOutput({tag, "_hs"}, 32'(smHs), 0);
        checkOutput({tag, "_vs"}, 32'(smVs), 0);
        checkOutput({tag, "_act"}, 32'(smAct), 0);
        checkOutput({tag, "_fs"}, 32'(smFs), 0);
        checkOutput({tag, "_fc"}, 32'(smFc), 0);
        checkOutput({tag, "_p1"}, 32'(smP1), 275);
        checkOutput({tag, "_p2"}, 32'(smP2), 275);
    endtask

    vec_t tblFull[7];
    vec_t tblSmall[8];

    initial begin
        int relFull, relSmall, relFast, fsBase, pulses, lastPulse;

        tblFull[0] = '{95,   10'd95,  10'd0, 1'b0, 1'b0, 1'b0};
        tblFull[1] = '{96,   10'd96,  10'd0, 1'b1, 1'b0, 1'b0};
        tblFull[2] = '{799,  10'd799, 10'd0, 1'b1, 1'b0, 1'b0};
        tblFull[3] = '{800,  10'd0,   10'd1, 1'b0, 1'b0, 1'b0};
        tblFull[4] = '{1044, 10'd244, 10'd1, 1'b1, 1'b0, 1'b0};
        tblFull[5] = '{1600, 10'd0,   10'd2, 1'b0, 1'b1, 1'b0};
        tblFull[6] = '{1700, 10'd100, 10'd2, 1'b1, 1'b1, 1'b0};

        tblSmall[0] = '{3,   10'd3,  10'd0, 1'b0, 1'b0, 1'b0};
        tblSmall[1] = '{4,   10'd4,  10'd0, 1'b1, 1'b0, 1'b0};
        tblSmall[2] = '{38,  10'd6,  10'd2, 1'b1, 1'b1, 1'b0};
        tblSmall[3] = '{53,  10'd5,  10'd3, 1'b1, 1'b1, 1'b0};
        tblSmall[4] = '{54,  10'd6,  10'd3, 1'b1, 1'b1, 1'b1};
        tblSmall[5] = '{62,  10'd14, 10'd3, 1'b1, 1'b1, 1'b0};
        tblSmall[6] = '{141, 10'd13, 10'd8, 1'b1, 1'b1, 1'b1};
        tblSmall[7] = '{150, 10'd6,  10'd9, 1'b1, 1'b1, 1'b0};

        applyStimulus(10'd0, 10'd0);
        tick(2);

        checkOutput("rst_full_tick", 32'(fullTick), 0);
        checkOutput("rst_full_x", 32'(fullX), 0);
        checkOutput("rst_full_hs", 32'(fullHs), 0);
        checkOutput("rst_full_p1", 32'(fullP1), 275);
        checkSmallReset("rst_small");
        checkOutput("rst_fast_tick", 32'(faTick), 1);

        rstFull = 1'b1;
        relFull = cyc;
        tick(1);
        checkOutput("full_e1_tick", 32'(fullTick), 0);
        checkOutput("full_e1_x", 32'(fullX), 0);
        tick(1);
        checkOutput("full_e2_tick", 32'(fullTick), 1);
        checkOutput("full_e2_x", 32'(fullX), 0);
        tick(1);
        checkOutput("full_e3_tick", 32'(fullTick), 0);
        checkOutput("full_e3_x", 32'(fullX), 1);

        for (int i = 0; i < 7; i++) begin
            gotoPixel(relFull, tblFull[i].pixel);
            checkVec("full", tblFull[i], fullX, fullY, fullHs, fullVs, fullAct);
        end
        checkOutput("full_no_fs", 32'(fsFullCnt), 0);
        checkOutput("full_fc", 32'(fullFc), 0);

        rstSmall = 1'b1;
        relSmall = cyc;
        for (int i = 0; i < 8; i++) begin
            gotoPixel(relSmall, tblSmall[i].pixel);
            checkVec("small", tblSmall[i], smX, smY, smHs, smVs, smAct);
        end

        applyStimulus(10'd100, 10'd7);
        gotoPixel(relSmall, 159);
        checkOutput("pre_wrap_p1", 32'(smP1), 275);
        checkOutput("pre_wrap_p2", 32'(smP2), 275);
        checkOutput("pre_wrap_no_fs", 32'(fsSmallCnt), 0);
        tick(1);
        applyStimulus(10'd100, 10'd600);
        tick(1);
        checkOutput("wrap_x", 32'(smX), 0);
        checkOutput("wrap_y", 32'(smY), 0);
        checkOutput("wrap_fs", 32'(smFs), 1);
        checkOutput("wrap_p1", 32'(smP1), 100);
        checkOutput("wrap_p2", 32'(smP2), 600);
        checkOutput("wrap_fc", 32'(smFc), 1);
        applyStimulus(10'd1, 10'd2);
        tick(1);
        checkOutput("post_wrap_fs", 32'(smFs), 0);
        checkOutput("post_wrap_p1", 32'(smP1), 100);

        gotoPixel(relSmall, 250);
        checkOutput("mid_x", 32'(smX), 10);
        checkOutput("mid_y", 32'(smY), 5);
        rstSmall = 1'b0;
        #1;
        checkSmallReset("midrst");
        tick(3);
        checkOutput("midrst_hold_x", 32'(smX), 0);
        rstSmall = 1'b1;
        relSmall = cyc;
        fsBase = fsSmallCnt;
        gotoPixel(relSmall, 1);
        checkOutput("restart_x", 32'(smX), 1);
        checkOutput("restart_y", 32'(smY), 0);
        gotoPixel(relSmall, 159);
        checkOutput("restart_no_fs", 32'(fsSmallCnt - fsBase), 0);
        gotoPixel(relSmall, 160);
        checkOutput("restart_wrap_fs", 32'(smFs), 1);
        checkOutput("restart_wrap_fc", 32'(smFc), 1);
        checkOutput("restart_wrap_p1", 32'(smP1), 1);

        rstFast = 1'b1;
        relFast = cyc;
        pulses = 0;
        lastPulse = 0;
        for (int k = 1; k <= 40960; k++) begin
            tick(1);
            if (k == 1) checkOutput("fast_x1", 32'(faX), 1);
            if (faFs) begin
                pulses++;
                checkOutput("fast_fs_spacing", 32'(k - lastPulse), 160);
                lastPulse = k;
            end
            if (k == 40800) checkOutput("fast_fc255", 32'(faFc), 255);
        end
        checkOutput("fast_pulses", 32'(pulses), 256);
        checkOutput("fast_fc_wrap", 32'(faFc), 0);
        checkOutput("fast_tick_high", 32'(faTick), 1);
        checkOutput("fast_rel_cycles", 32'(cyc - relFast), 40960);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
